// File: rtl/uart_word_io.sv
// rtl/uart_word_io.sv - word-level bridge between a byte-wide UART receiver/sender pair and a word-wide consumer
//
// Ports:
//   i_clk, i_rst               clock (rising edge), asynchronous active-high reset
//   i_rx_byte, i_rx_byte_valid received byte and its one-cycle strobe
//   o_rx_word, o_rx_word_valid word at the head of the RX FIFO (first-word-fall-through)
//   i_rx_word_pop              consume the head word
//   o_rx_count                 number of words held in the RX FIFO
//   i_tx_word, i_tx_word_valid word to send and its request
//   o_tx_word_ready            TX path idle and able to take a word
//   o_tx_byte, o_tx_byte_valid byte towards the sender
//   i_tx_byte_ready            sender accepts the byte
//   o_err_overflow             sticky: completed RX word dropped on a full FIFO
//   o_err_timeout              sticky: partial RX word discarded by the inter-byte timeout
//   i_err_clear                clears both sticky flags
module uart_word_io #(
    parameter int WORD_BYTES = 4,
    parameter int BIG_ENDIAN = 1,
    parameter int RX_DEPTH   = 4,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_rx_byte,
    input  logic                          i_rx_byte_valid,
    output logic [8*WORD_BYTES-1:0]       o_rx_word,
    output logic                          o_rx_word_valid,
    input  logic                          i_rx_word_pop,
    output logic [$clog2(RX_DEPTH+1)-1:0] o_rx_count,
    input  logic [8*WORD_BYTES-1:0]       i_tx_word,
    input  logic                          i_tx_word_valid,
    output logic                          o_tx_word_ready,
    output logic [7:0]                    o_tx_byte,
    output logic                          o_tx_byte_valid,
    input  logic                          i_tx_byte_ready,
    output logic                          o_err_overflow,
    output logic                          o_err_timeout,
    input  logic                          i_err_clear
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(RX_DEPTH + 1);
    localparam int TW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

    // ------------------------------------------------------------------
    // RX byte assembly
    // ------------------------------------------------------------------
    logic [IW-1:0] r_rx_k;
    logic [W-1:0]  r_rx_partial;
    logic          w_rx_expire;
    logic [IW-1:0] w_rx_k_eff;
    logic [W-1:0]  w_rx_base;
    logic [IW-1:0] w_rx_lane;
    logic [W-1:0]  w_rx_assembled;
    logic          w_rx_last;

    // On the expiry cycle the stale partial word is already gone, so a byte
    // arriving in that same cycle starts a fresh word at index 0.
    assign w_rx_k_eff = w_rx_expire ? '0 : r_rx_k;
    assign w_rx_base  = w_rx_expire ? '0 : r_rx_partial;
    assign w_rx_lane  = (BIG_ENDIAN != 0) ? (LAST_IDX - w_rx_k_eff) : w_rx_k_eff;
    assign w_rx_last  = i_rx_byte_valid && (w_rx_k_eff == LAST_IDX);

    always_comb begin
        w_rx_assembled = w_rx_base;
        w_rx_assembled[{w_rx_lane, 3'b000} +: 8] = i_rx_byte;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_k       <= '0;
            r_rx_partial <= '0;
        end else if (i_rx_byte_valid) begin
            r_rx_k       <= w_rx_last ? '0 : (w_rx_k_eff + IW'(1));
            r_rx_partial <= w_rx_last ? '0 : w_rx_assembled;
        end else if (w_rx_expire) begin
            r_rx_k       <= '0;
            r_rx_partial <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout: counts idle cycles only while a word is partial
    // ------------------------------------------------------------------
    generate
        if (RX_TIMEOUT > 0) begin : g_timeout
            logic [TW-1:0] r_to_cnt;

            assign w_rx_expire = (r_rx_k != '0) && (r_to_cnt == TW'(RX_TIMEOUT));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_to_cnt <= '0;
                end else if (i_rx_byte_valid || (r_rx_k == '0) || w_rx_expire) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end else begin : g_no_timeout
            assign w_rx_expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Completed-word FIFO
    // ------------------------------------------------------------------
    logic [W-1:0]  r_fifo [RX_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a push when it is being popped.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = i_rx_word_pop && (r_count != '0);
    assign w_push = w_rx_last && (!w_full || w_pop);
    assign w_drop = w_rx_last && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_rx_assembled;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; gating on empty keeps the output at zero after reset.
    assign o_rx_word       = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
    assign o_rx_word_valid = (r_count != '0);
    assign o_rx_count      = r_count;

    // ------------------------------------------------------------------
    // Sticky error flags: a set event beats a simultaneous clear
    // ------------------------------------------------------------------
    logic r_err_overflow;
    logic r_err_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_err_overflow <= (r_err_overflow && !i_err_clear) || w_drop;
            r_err_timeout  <= (r_err_timeout  && !i_err_clear) || w_rx_expire;
        end
    end

    assign o_err_overflow = r_err_overflow;
    assign o_err_timeout  = r_err_timeout;

    // ------------------------------------------------------------------
    // TX word serialiser
    // ------------------------------------------------------------------
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    tx_state_t     r_tx_state;
    tx_state_t     w_tx_state_next;
    logic [W-1:0]  r_tx_word;
    logic [W-1:0]  w_tx_word_next;
    logic [IW-1:0] r_tx_j;
    logic [IW-1:0] w_tx_j_next;
    logic [IW-1:0] w_tx_lane;
    logic          r_tx_armed;

    // r_tx_armed holds tx_word_ready low until the first clock edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_word  <= '0;
            r_tx_j     <= '0;
            r_tx_armed <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_word  <= w_tx_word_next;
            r_tx_j     <= w_tx_j_next;
            r_tx_armed <= 1'b1;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_word_next  = r_tx_word;
        w_tx_j_next     = r_tx_j;
        o_tx_word_ready = 1'b0;
        o_tx_byte_valid = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                o_tx_word_ready = r_tx_armed;
                if (r_tx_armed && i_tx_word_valid) begin
                    w_tx_word_next  = i_tx_word;
                    w_tx_j_next     = '0;
                    w_tx_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                o_tx_byte_valid = 1'b1;
                if (i_tx_byte_ready) begin
                    if (r_tx_j == LAST_IDX) begin
                        w_tx_j_next     = '0;
                        w_tx_state_next = TX_IDLE;
                    end else begin
                        w_tx_j_next = r_tx_j + IW'(1);
                    end
                end
            end
            default: begin
                w_tx_state_next = TX_IDLE;
            end
        endcase
    end

    assign w_tx_lane = (BIG_ENDIAN != 0) ? (LAST_IDX - r_tx_j) : r_tx_j;
    assign o_tx_byte = r_tx_word[{w_tx_lane, 3'b000} +: 8];

endmodule

// File: doc/uart_word_io.md
Name: uart_word_io

Overview:
Parametrised word-level bridge between the byte-wide UART receiver/sender pair and the core or instruction loader. It replaces the per-instruction byte-sequencing state in the core.
- RX side: assembles WORD_BYTES received bytes into a word and buffers completed words in a small FIFO.
- TX side: serialises a word into bytes through a valid/ready handshake to the sender.
- Adds configurable byte order, an inter-byte timeout for resynchronisation, and sticky error flags.

Parameters:
WORD_BYTES, 4, bytes per word; word width W = 8*WORD_BYTES; legal range 1..8
BIG_ENDIAN, 1, 1 = first byte on the wire is the most significant byte; 0 = first byte is the least significant byte
RX_DEPTH, 4, completed-word FIFO depth; power of two, minimum 2
RX_TIMEOUT, 100000, idle cycles after which a partial RX word is discarded; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
rx_byte  in  8  byte from receiver
rx_byte_valid  in  1  one-cycle pulse; rx_byte is valid in that cycle
rx_word  out  W  word at the FIFO head (first-word-fall-through)
rx_word_valid  out  1  FIFO not empty
rx_word_pop  in  1  consume the head word
rx_count  out  clog2(RX_DEPTH+1)  number of words in the FIFO
tx_word  in  W  word to send
tx_word_valid  in  1  send request
tx_word_ready  out  1  high when the TX path can accept a word
tx_byte  out  8  byte to sender
tx_byte_valid  out  1  tx_byte is valid
tx_byte_ready  in  1  sender accepts the byte when valid and ready are both high
err_overflow  out  1  sticky: a completed word was dropped because the FIFO was full
err_timeout  out  1  sticky: a partial word was discarded by the timeout
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs: all 0, including tx_word_ready.
  - RX: assembly byte index = 0, partial word cleared, FIFO empty, timeout counter = 0.
  - TX: FSM in IDLE.
  - tx_word_ready rises on the first CLK edge after RST deasserts.
  - Reset mid-operation drops the partial RX word, all FIFO contents and any in-flight TX word. tx_byte_valid falls immediately.
- RX assembly:
  - Each rx_byte_valid cycle stores the byte at index k (k = 0 first). k increments, wrapping to 0 after WORD_BYTES-1.
  - BIG_ENDIAN=1: byte k goes to bits [W-1-8k : W-8-8k]. BIG_ENDIAN=0: byte k goes to bits [8k+7 : 8k].
  - On the last byte, the completed word is pushed. It appears on rx_word / rx_word_valid in the cycle after the final rx_byte_valid (latency 1).
- FIFO:
  - Circular buffer with read and write pointers wrapping modulo RX_DEPTH.
  - Pop when empty is ignored.
  - Push and pop in the same cycle both take effect, including when the FIFO is full. rx_count is unchanged.
  - Push when full with no pop: the word is dropped, FIFO contents are unchanged, err_overflow is set.
- Timeout (RX_TIMEOUT > 0):
  - The counter clears on every rx_byte_valid and when k = 0.
  - While k > 0, the counter increments each cycle with no byte.
  - When the counter reaches RX_TIMEOUT: k and the counter return to 0, the partial word is discarded, err_timeout is set.
  - A byte arriving in the same cycle as expiry is taken as byte 0 of a new word.
- Sticky flags: err_clear clears both flags. If a set event and err_clear occur in the same cycle, the set wins.
- TX FSM, states IDLE and SEND:
  - IDLE:
    - tx_word_ready=1 and tx_byte_valid=0.
    - When tx_word_valid=1, capture tx_word, set j=0, go to SEND. tx_word_ready drops the next cycle.
  - SEND:
    - tx_byte_valid=1 and tx_byte = byte j of the captured word, using the same ordering as RX.
    - tx_byte and the captured word stay stable until accepted.
    - On tx_byte_ready: j increments. After byte WORD_BYTES-1 is accepted, go to IDLE.
  - Minimum word period is WORD_BYTES+1 cycles.
  - tx_word_valid is ignored outside IDLE.
- RX and TX are fully independent. Simultaneous activity on both sides is legal.

Test Plan:
1. BIG_ENDIAN=1, WORD_BYTES=4; bytes 00,00,00,EC pulsed 10 cycles apart -> rx_word=0x000000EC, rx_word_valid=1 one cycle after the 4th pulse, rx_count=1.
2. BIG_ENDIAN=0; bytes 20,00,00,02 -> rx_word=0x02000020. TX of 0x000000F0 with tx_byte_ready held high -> tx_byte sequence F0,00,00,00 on 4 consecutive cycles, then tx_word_ready=1.
3. RX_DEPTH=4; push 5 words with no pops -> rx_count=4, err_overflow=1, head is word 1. Pop and push a 6th word in the same cycle -> rx_count stays 4. err_clear -> err_overflow=0.
4. RX_TIMEOUT=16; send 2 bytes then idle 16 cycles -> err_timeout=1, no word pushed. Then send 4 bytes AA,BB,CC,DD -> rx_word=0xAABBCCDD.
5. TX with tx_byte_ready toggling 1-0-0-1 -> tx_byte holds each byte until accepted, exactly 4 acceptances, no duplicated or skipped bytes.
6. Assert RST after 2 TX bytes and 1 RX byte -> tx_byte_valid=0 immediately, rx_count=0. After release, new word 0x11223344 is received and sent correctly.
